hw_semaphore: RTL and testbench
===============================

// Module: hw_semaphore
// PURPOSE
//  Counting hardware semaphore that arbitrates NUM_REQ requesters for MAX_COUNT shared tokens.
//  It is the DUT stage the Teal semaphore test drives: the top level feeds req/rel from Teal-controlled regs.
//  The test reads grant/held/count back through VPI.
//  Round-robin fairness; at most one grant per cycle; illegal releases are flagged, never corrupt the count.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..16)
//  MAX_COUNT     2    tokens available after reset (1..NUM_REQ)
//  HOLD_TIMEOUT  64   cycles a token may be held before forced release (timeout feature only)
// PORTS
//  clk        in   1              single clock, all state on posedge clk
//  reset      in   1              asynchronous, active-high; clears all state immediately
//  req        in   NUM_REQ        level; requester i wants a token, held until its grant pulse
//  rel        in   NUM_REQ        1-cycle pulse; requester i returns its token
//  grant      out  NUM_REQ        1-cycle pulse, one-hot or zero; token handed to requester i
//  held       out  NUM_REQ        level; requester i currently owns a token
//  count      out  CNT_W          tokens free; CNT_W = $clog2(MAX_COUNT+1)
//  err_rel    out  1              1-cycle pulse; rel[i] seen while held[i]==0
//  timeout    out  NUM_REQ        1-cycle pulse; forced release of requester i (0 when feature off)
// BEHAVIOUR
//  Reset values: grant=0, held=0, count=MAX_COUNT, err_rel=0, timeout=0, rr pointer=0, all FSMs IDLE.
//  Per-requester FSM: IDLE -(req)-> WAIT -(grant)-> HELD -(rel or timeout)-> IDLE.
//   WAIT->IDLE if req drops before grant (withdrawal, no token consumed).
//   req while HELD ignored: a requester never owns two tokens.
//  Grant decision in cycle t uses registered count(t); grant[i] and held[i] rise at t+1 together.
//   count decrements at t+1; grant requires count>0 and at least one WAIT requester.
//  Arbitration: round-robin starting at pointer; pointer moves to winner+1 (mod NUM_REQ) after each grant.
//  Release: rel[i] while HELD -> held[i]=0 and count += 1 at t+1; token usable by a grant from t+1 on.
//   Multiple releases in one cycle are all accepted; count += number of valid releases.
//  Simultaneous grant and release same cycle: count(t+1) = count(t) - grant + valid_releases.
//   A release never enables a grant in the same cycle (no combinational rel->grant path).
//  Illegal rel (requester not HELD): ignored, err_rel pulses at t+1; several in one cycle give one pulse.
//  count never exceeds MAX_COUNT nor underflows; assertion fires if it would.
//  Reset mid-operation: all tokens reclaimed; outstanding grants/holds dropped, no err_rel generated.
//  Latency: req->grant minimum 1 cycle; rel->count update 1 cycle.
// CONFIGURATION
//  HW_SEMAPHORE_TIMEOUT_EN defined: per-requester hold counter, cleared on grant.
//   At HOLD_TIMEOUT cycles held, the token is forcibly released: held[i]=0, count+1, timeout[i] pulses.
//   A rel[i] in the same cycle as the timeout counts as one release; no err_rel.
//  HW_SEMAPHORE_TIMEOUT_EN undefined: no counters instantiated, timeout tied to 0, holds unbounded.
// STRUCTURE
//  hw_semaphore_pkg: typedef enum {SEM_IDLE, SEM_WAIT, SEM_HELD} sem_state_t;
//   also a cnt_width() function and HOLD_CNT_W constant.
//  Sub-module rr_arbiter: NUM_REQ-wide round-robin, inputs request vector, enable, pointer.
//   Outputs are a one-hot winner and a valid flag.
//  hw_semaphore holds the FSM array, token counter, error logic and optional timeout counters.
// TESTING
//  Reset: count==2, held==0, grant==0 immediately on reset rise without a clock edge.
//  Contention: req=4'b1111 at cycle 10 -> grants to r0 (c11), r1 (c12); count 0; r2,r3 wait.
//  Release/refill: rel[0] at c20 -> count 1 at c21; grant r2 at c22; pointer then 3.
//   rel[1] and rel[2] same cycle -> count += 2.
//  Simultaneous: count=1, req r3 waiting, rel[2] in same cycle as grant r3 -> count stays 1.
//  Illegal release: rel[3] while r3 IDLE -> err_rel pulse next cycle, count unchanged.
//   Withdrawal: req[1] dropped while WAIT -> no grant, count unchanged.
//  Timeout (macro on, HOLD_TIMEOUT=8): r0 granted at c5, no rel -> timeout[0] at c13.
//   count restored at c13; macro off -> r0 still held at c100.

Source files
------------

// File: rtl/hw_semaphore_pkg.sv
// rtl/hw_semaphore_pkg.sv - shared types and sizing helpers for the counting semaphore
package hw_semaphore_pkg;

    typedef enum logic [1:0] {
        SEM_IDLE = 2'd0,
        SEM_WAIT = 2'd1,
        SEM_HELD = 2'd2
    } sem_state_t;

    // Width of the per-requester hold counter; HOLD_TIMEOUT must fit in it.
    localparam int HOLD_CNT_W = 16;

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/hw_semaphore_if.sv
// rtl/hw_semaphore_if.sv - request/release/grant bundle between requesters and the semaphore
interface hw_semaphore_if
    import hw_semaphore_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_COUNT = 2
);
    localparam int CNT_W = cnt_width(MAX_COUNT);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rel;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] held;
    logic [CNT_W-1:0]   count;
    logic               err_rel;
    logic [NUM_REQ-1:0] timeout;

    modport master (output req, rel, input grant, held, count, err_rel, timeout);
    modport slave  (input req, rel, output grant, held, count, err_rel, timeout);

endinterface

// File: rtl/hw_semaphore_rr_arbiter.sv
// rtl/hw_semaphore_rr_arbiter.sv - round-robin pick of one requester starting at a pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         request,
    input  logic                       enable,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [NUM_REQ-1:0]         winner,
    output logic                       valid
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(pointer) + k) % NUM_REQ;
            if (enable && !valid && request[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hw_semaphore.sv
// rtl/hw_semaphore.sv - counting semaphore with round-robin grants over NUM_REQ requesters
// Optional forced release after HOLD_TIMEOUT held cycles: define HW_SEMAPHORE_TIMEOUT_EN.
module hw_semaphore
    import hw_semaphore_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_COUNT    = 2,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    hw_semaphore_if.slave  bus
);
    localparam int CNT_W = cnt_width(MAX_COUNT);
    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_COUNT < 1 || MAX_COUNT > NUM_REQ ||
        HOLD_TIMEOUT < 1 || HOLD_TIMEOUT >= 2**HOLD_CNT_W) begin : g_bad_params
        $error("hw_semaphore: parameter out of range");
    end

    sem_state_t         state      [NUM_REQ];
    sem_state_t         state_next [NUM_REQ];
    logic [CNT_W-1:0]   count_q, count_next;
    logic [PTR_W-1:0]   ptr_q, ptr_next;
    logic [NUM_REQ-1:0] grant_q, held_vec, eligible, valid_rel, illegal_rel, expire, winner;
    logic               err_q, arb_valid;
    int                 count_sum;

    // Arbitration sees only registered count, so a release cannot fund a same-cycle grant.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .request (eligible),
        .enable  (count_q != '0),
        .pointer (ptr_q),
        .winner  (winner),
        .valid   (arb_valid)
    );

    always_comb begin
        held_vec    = '0;
        eligible    = '0;
        valid_rel   = '0;
        illegal_rel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            held_vec[i]    = (state[i] == SEM_HELD);
            eligible[i]    = bus.req[i] && (state[i] != SEM_HELD);
            valid_rel[i]   = (state[i] == SEM_HELD) && (bus.rel[i] || expire[i]);
            illegal_rel[i] = bus.rel[i] && (state[i] != SEM_HELD);
        end
    end

    always_comb begin
        count_sum = int'(count_q) - int'(arb_valid);
        ptr_next  = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            state_next[i] = state[i];
            case (state[i])
                SEM_IDLE: if (winner[i]) state_next[i] = SEM_HELD;
                          else if (bus.req[i]) state_next[i] = SEM_WAIT;
                SEM_WAIT: if (winner[i]) state_next[i] = SEM_HELD;
                          else if (!bus.req[i]) state_next[i] = SEM_IDLE;
                SEM_HELD: if (valid_rel[i]) state_next[i] = SEM_IDLE;
                default:  state_next[i] = SEM_IDLE;
            endcase
            count_sum = count_sum + int'(valid_rel[i]);
            if (winner[i]) ptr_next = PTR_W'((i + 1) % NUM_REQ);
        end
        count_next = CNT_W'(count_sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) state[i] <= SEM_IDLE;
            count_q <= CNT_W'(MAX_COUNT);
            ptr_q   <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            assert (count_sum >= 0 && count_sum <= MAX_COUNT);
            state   <= state_next;
            count_q <= count_next;
            ptr_q   <= ptr_next;
            grant_q <= winner;
            err_q   <= |illegal_rel;
        end
    end

`ifdef HW_SEMAPHORE_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]    timeout_q;

    always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_REQ; i++)
            expire[i] = held_vec[i] && (hold_cnt[i] == HOLD_CNT_W'(HOLD_TIMEOUT - 1));
    end

    // Counter reads 0 during the first held cycle, so expiry lands after exactly HOLD_TIMEOUT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) hold_cnt[i] <= '0;
            timeout_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (winner[i] || !held_vec[i]) hold_cnt[i] <= '0;
                else                           hold_cnt[i] <= hold_cnt[i] + HOLD_CNT_W'(1);
            end
            timeout_q <= expire;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = '0;
    assign bus.timeout = '0;
`endif

    assign bus.grant   = grant_q;
    assign bus.held    = held_vec;
    assign bus.count   = count_q;
    assign bus.err_rel = err_q;

endmodule

// File: tb/tb_hw_semaphore.sv
// tb/tb_hw_semaphore.sv - scoreboard bench for hw_semaphore (4 requesters, 2 tokens)
module tb_hw_semaphore;

    localparam int HT = 8;
`ifdef HW_SEMAPHORE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] grant;
        logic [3:0] held;
        logic [1:0] count;
        logic       err_rel;
        logic [3:0] timeout;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    int m_st [4];
    int m_hold [4];
    int m_cnt;
    int m_ptr;

    hw_semaphore_if #(.NUM_REQ(4), .MAX_COUNT(2)) sif ();

    hw_semaphore #(.NUM_REQ(4), .MAX_COUNT(2), .HOLD_TIMEOUT(HT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i]   = 0;
            m_hold[i] = 0;
        end
        m_cnt = 2;
        m_ptr = 0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Drive one cycle of req/rel, predict the registered outputs, then capture the DUT's.
    task automatic step(input logic [3:0] r, input logic [3:0] l);
        obs_t       e;
        int         win;
        int         idx;
        logic [3:0] to;
        logic [3:0] vrel;
        sif.req = r;
        sif.rel = l;
        e   = '0;
        win = -1;
        if (m_cnt > 0)
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (win < 0 && r[idx] && m_st[idx] != 2) win = idx;
            end
        for (int i = 0; i < 4; i++) begin
            to[i]   = TO_EN && m_st[i] == 2 && m_hold[i] == HT - 1;
            vrel[i] = (m_st[i] == 2) && (l[i] || to[i]);
            if (l[i] && m_st[i] != 2) e.err_rel = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            if (i == win) begin
                m_st[i]   = 2;
                m_hold[i] = 0;
            end else if (m_st[i] == 2) begin
                if (vrel[i]) m_st[i] = 0;
                else m_hold[i]++;
            end else if (m_st[i] == 1 && !r[i]) m_st[i] = 0;
            else if (m_st[i] == 0 && r[i]) m_st[i] = 1;
        end
        if (win >= 0) begin
            m_cnt--;
            m_ptr = (win + 1) % 4;
            e.grant[win] = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            m_cnt += int'(vrel[i]);
            e.held[i] = (m_st[i] == 2);
        end
        e.count   = 2'(m_cnt);
        e.timeout = to;
        exp_q.push_back(e);
        @(posedge clk); #1;
        obs_q.push_back({sif.grant, sif.held, sif.count, sif.err_rel, sif.timeout});
        sif.rel = '0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        apply_reset();
        step(4'b0001, 4'b0000);
        step(4'b0010, 4'b0000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_pre: got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b",
                         o.grant, o.held, o.count, o.err_rel, o.timeout, e.grant, e.held, e.count, e.err_rel, e.timeout);
            end
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (sif.count !== 2'd2) begin n_bad++; $display("FAIL reset_count: got %0d want 2", sif.count); end
        n_cmp++; if (sif.held !== 4'b0000) begin n_bad++; $display("FAIL reset_held: got %b want 0000", sif.held); end
        n_cmp++; if (sif.grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", sif.grant); end
        n_cmp++; if (sif.err_rel !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", sif.err_rel); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_contention();
        obs_t e, o;
        step(4'b1111, 4'b0000);
        n_cmp++; if (sif.grant !== 4'b0001) begin n_bad++; $display("FAIL cont_g0: got %b want 0001", sif.grant); end
        step(4'b1111, 4'b0000);
        n_cmp++; if (sif.grant !== 4'b0010) begin n_bad++; $display("FAIL cont_g1: got %b want 0010", sif.grant); end
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b0000);
        n_cmp++; if (sif.count !== 2'd0) begin n_bad++; $display("FAIL cont_count: got %0d want 0", sif.count); end
        n_cmp++; if (sif.held !== 4'b0011) begin n_bad++; $display("FAIL cont_held: got %b want 0011", sif.held); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL contention: got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b",
                         o.grant, o.held, o.count, o.err_rel, o.timeout, e.grant, e.held, e.count, e.err_rel, e.timeout);
            end
        end
    endtask

    task automatic test_release_refill();
        obs_t e, o;
        step(4'b1100, 4'b0001);
        n_cmp++; if (sif.count !== 2'd1 || sif.grant !== 4'b0000) begin
            n_bad++; $display("FAIL refill_rel0: got count=%0d grant=%b want count=1 grant=0000", sif.count, sif.grant); end
        step(4'b1100, 4'b0000);
        n_cmp++; if (sif.grant !== 4'b0100) begin n_bad++; $display("FAIL refill_g2: got %b want 0100", sif.grant); end
        step(4'b1000, 4'b0110);
        n_cmp++; if (sif.count !== 2'd2) begin n_bad++; $display("FAIL refill_dual_rel: got %0d want 2", sif.count); end
        step(4'b1011, 4'b0000);
        n_cmp++; if (sif.grant !== 4'b1000) begin n_bad++; $display("FAIL refill_ptr3: got %b want 1000", sif.grant); end
        step(4'b1011, 4'b0000);
        n_cmp++; if (sif.grant !== 4'b0001) begin n_bad++; $display("FAIL refill_wrap: got %b want 0001", sif.grant); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL refill: got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b",
                         o.grant, o.held, o.count, o.err_rel, o.timeout, e.grant, e.held, e.count, e.err_rel, e.timeout);
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t e, o;
        step(4'b0000, 4'b1000);
        step(4'b0100, 4'b0000);
        step(4'b0000, 4'b0001);
        step(4'b1000, 4'b0100);
        n_cmp++; if (sif.count !== 2'd1) begin n_bad++; $display("FAIL simul_count: got %0d want 1", sif.count); end
        n_cmp++; if (sif.grant !== 4'b1000 || sif.held !== 4'b1000) begin
            n_bad++; $display("FAIL simul_grant: got grant=%b held=%b want 1000/1000", sif.grant, sif.held); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL simultaneous: got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b",
                         o.grant, o.held, o.count, o.err_rel, o.timeout, e.grant, e.held, e.count, e.err_rel, e.timeout);
            end
        end
    endtask

    task automatic test_illegal_withdraw();
        obs_t e, o;
        step(4'b0000, 4'b0001);
        n_cmp++; if (sif.err_rel !== 1'b1 || sif.count !== 2'd1) begin
            n_bad++; $display("FAIL illegal_rel: got err=%b count=%0d want 1/1", sif.err_rel, sif.count); end
        step(4'b0000, 4'b0111);
        step(4'b0000, 4'b0000);
        n_cmp++; if (sif.err_rel !== 1'b0) begin n_bad++; $display("FAIL illegal_pulse: got %b want 0", sif.err_rel); end
        step(4'b0001, 4'b0000);
        step(4'b0010, 4'b0000);
        step(4'b0000, 4'b0000);
        step(4'b0000, 4'b0001);
        step(4'b0000, 4'b0000);
        n_cmp++; if (sif.grant !== 4'b0000 || sif.count !== 2'd1) begin
            n_bad++; $display("FAIL withdraw: got grant=%b count=%0d want 0000/1", sif.grant, sif.count); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL illegal_withdraw: got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b",
                         o.grant, o.held, o.count, o.err_rel, o.timeout, e.grant, e.held, e.count, e.err_rel, e.timeout);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        step(4'b0100, 4'b0000);
        sif.rel = 4'b1000;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        sif.rel = '0;
        sif.req = '0;
        reset   = 1'b0;
        model_reset();
        step(4'b0000, 4'b0000);
        n_cmp++; if (sif.err_rel !== 1'b0 || sif.count !== 2'd2 || sif.held !== 4'b0000) begin
            n_bad++; $display("FAIL reset_mid: got err=%b count=%0d held=%b want 0/2/0000", sif.err_rel, sif.count, sif.held); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid_sb: got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b",
                         o.grant, o.held, o.count, o.err_rel, o.timeout, e.grant, e.held, e.count, e.err_rel, e.timeout);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t e, o;
        apply_reset();
        step(4'b0001, 4'b0000);
`ifdef HW_SEMAPHORE_TIMEOUT_EN
        repeat (HT - 1) step(4'b0000, 4'b0000);
        n_cmp++; if (sif.held !== 4'b0001) begin n_bad++; $display("FAIL tmo_held: got %b want 0001", sif.held); end
        step(4'b0000, 4'b0000);
        n_cmp++; if (sif.timeout !== 4'b0001 || sif.count !== 2'd2 || sif.held !== 4'b0000) begin
            n_bad++; $display("FAIL tmo_fire: got to=%b count=%0d held=%b want 0001/2/0000", sif.timeout, sif.count, sif.held); end
`else
        repeat (95) step(4'b0000, 4'b0000);
        n_cmp++; if (sif.held !== 4'b0001 || sif.count !== 2'd1 || sif.timeout !== 4'b0000) begin
            n_bad++; $display("FAIL no_tmo: got held=%b count=%0d to=%b want 0001/1/0000", sif.held, sif.count, sif.timeout); end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL timeout_sb: got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b",
                         o.grant, o.held, o.count, o.err_rel, o.timeout, e.grant, e.held, e.count, e.err_rel, e.timeout);
            end
        end
    endtask

    task automatic test_random();
        obs_t e, o;
        apply_reset();
        for (int n = 0; n < 400; n++)
            step(4'($urandom), 4'($urandom & $urandom & $urandom));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random: got %b_%b_%0d_%b_%b want %b_%b_%0d_%b_%b",
                         o.grant, o.held, o.count, o.err_rel, o.timeout, e.grant, e.held, e.count, e.err_rel, e.timeout);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        sif.req = '0;
        sif.rel = '0;
        model_reset();
        test_reset();
        test_contention();
        test_release_refill();
        test_simultaneous();
        test_illegal_withdraw();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
